// File: rtl/mul_flux_scheduler.sv
// mul_flux_scheduler: round-robin sequencer for the shared
// multi-flux multiplier; tracks per-flux size x size blocks.
module mul_flux_scheduler #(
  parameter int FLUX           = 2,
  parameter int TAG_WIDTH      = (FLUX > 1) ? $clog2(FLUX) : 1,
  parameter int DATA_WIDTH_EXT = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FLUX-1:0]                opa_empty,
  input  logic [FLUX-1:0]                opb_empty,
  input  logic [FLUX-1:0]                ext_size_empty,
  input  logic [FLUX*DATA_WIDTH_EXT-1:0] ext_size_head,
  input  logic [FLUX-1:0]                prod_full,
  output logic [FLUX-1:0]                opa_read,
  output logic [FLUX-1:0]                opb_read,
  output logic [FLUX-1:0]                ext_size_read,
  output logic                           load_valid,
  output logic                           issue_valid,
  output logic [TAG_WIDTH-1:0]           grant_tag,
  output logic                           block_last,
  output logic                           zero_size,
  output logic [FLUX-1:0]                busy
);

  localparam int W = DATA_WIDTH_EXT;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  state_t               state_q [FLUX];
  logic [W-1:0]         max_q   [FLUX];
  logic [W-1:0]         cnt_h_q [FLUX];
  logic [W-1:0]         cnt_v_q [FLUX];
  logic [TAG_WIDTH-1:0] rr_ptr_q;

  logic [FLUX-1:0]      elig;
  logic                 found;
  logic [TAG_WIDTH-1:0] gnt;
  logic [TAG_WIDTH-1:0] ptr_d;

  state_t               st_g;
  logic [W-1:0]         max_g;
  logic [W-1:0]         h_g;
  logic [W-1:0]         v_g;
  logic [W-1:0]         sel_size;

  state_t               st_d;
  logic [W-1:0]         max_d;
  logic [W-1:0]         h_d;
  logic [W-1:0]         v_d;

  logic                 do_load;
  logic                 do_issue;
  logic                 last;
  logic                 zero;
  logic [FLUX-1:0]      onehot;

  // a flux may load when idle, or issue when working
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      if (state_q[i] == IDLE) begin
        elig[i] = !opb_empty[i] && !ext_size_empty[i];
      end else begin
        elig[i] = !opa_empty[i] && !prod_full[i];
      end
    end
  end

  // rotating search from rr_ptr, first eligible flux wins
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < FLUX; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= FLUX) begin
        idx = idx - FLUX;
      end
      for (int i = 0; i < FLUX; i++) begin
        if (!found && i == idx && elig[i]) begin
          found = 1'b1;
          gnt   = TAG_WIDTH'(i);
        end
      end
    end
  end

  // view of the granted flux registers and head
  always_comb begin
    st_g     = IDLE;
    max_g    = '0;
    h_g      = '0;
    v_g      = '0;
    sel_size = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (gnt == TAG_WIDTH'(i)) begin
        st_g     = state_q[i];
        max_g    = max_q[i];
        h_g      = cnt_h_q[i];
        v_g      = cnt_v_q[i];
        sel_size = ext_size_head[i*W +: W];
      end
    end
  end

  // next state of the granted flux and handshake outputs
  always_comb begin
    st_d     = st_g;
    max_d    = max_g;
    h_d      = h_g;
    v_d      = v_g;
    do_load  = 1'b0;
    do_issue = 1'b0;
    last     = 1'b0;
    zero     = 1'b0;
    if (found && rst) begin
      if (st_g == IDLE) begin
        do_load = 1'b1;
        if (sel_size == '0) begin
          zero = 1'b1;
        end else begin
          st_d  = WORK;
          max_d = sel_size;
          h_d   = '0;
          v_d   = '0;
        end
      end else begin
        do_issue = 1'b1;
        if (h_g < max_g - W'(1)) begin
          h_d = h_g + W'(1);
        end else if (v_g < max_g - W'(1)) begin
          h_d = '0;
          v_d = v_g + W'(1);
        end else begin
          last = 1'b1;
          h_d  = '0;
          v_d  = '0;
          st_d = IDLE;
        end
      end
    end
  end

  // strobes are one-hot on the granted flux
  always_comb begin
    for (int i = 0; i < FLUX; i++) begin
      onehot[i] = found && rst && (gnt == TAG_WIDTH'(i));
      busy[i]   = (state_q[i] == WORK);
    end
    opa_read      = do_issue ? onehot : '0;
    opb_read      = do_load ? onehot : '0;
    ext_size_read = do_load ? onehot : '0;
    load_valid    = do_load;
    issue_valid   = do_issue;
    block_last    = last;
    zero_size     = zero;
    grant_tag     = rst ? gnt : '0;
    if (int'(gnt) >= FLUX - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt + TAG_WIDTH'(1);
    end
  end

  // only the granted flux and the pointer move on a grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < FLUX; i++) begin
        state_q[i] <= IDLE;
        max_q[i]   <= '0;
        cnt_h_q[i] <= '0;
        cnt_v_q[i] <= '0;
      end
    end else if (do_load || do_issue) begin
      rr_ptr_q <= ptr_d;
      for (int i = 0; i < FLUX; i++) begin
        if (gnt == TAG_WIDTH'(i)) begin
          state_q[i] <= st_d;
          max_q[i]   <= max_d;
          cnt_h_q[i] <= h_d;
          cnt_v_q[i] <= v_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_flux_scheduler.sv
// tb_mul_flux_scheduler: vectors and scoreboard for the
// scheduler at FLUX=1, 2 and 3.
module tb_mul_flux_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] ob;
    logic       lv;
    logic       iv;
    int         tag;
    logic       bl;
    logic [1:0] bz;
  } vec_t;

  typedef struct packed {
    logic       ld;
    logic [1:0] tag;
    logic       last;
  } exp_t;

  vec_t vt [21];
  exp_t sb [$];
  exp_t e;
  int   ni [3];

  // FLUX=1
  logic [0:0] opa_e1, opb_e1, ext_e1, pf1;
  logic [6:0] head1;
  logic [0:0] opa_r1, opb_r1, ext_r1, busy1, tag1;
  logic       lv1, iv1, bl1, zs1;

  // FLUX=2
  logic [1:0]  opa_e2, opb_e2, ext_e2, pf2;
  logic [13:0] head2;
  logic [1:0]  opa_r2, opb_r2, ext_r2, busy2;
  logic [0:0]  tag2;
  logic        lv2, iv2, bl2, zs2;

  // FLUX=3
  logic [2:0]  opa_e3, opb_e3, ext_e3, pf3;
  logic [20:0] head3;
  logic [2:0]  opa_r3, opb_r3, ext_r3, busy3;
  logic [1:0]  tag3;
  logic        lv3, iv3, bl3, zs3;

  mul_flux_scheduler #(.FLUX(1)) u1 (
    .clk(clk), .rst(rst),
    .opa_empty(opa_e1), .opb_empty(opb_e1),
    .ext_size_empty(ext_e1), .ext_size_head(head1),
    .prod_full(pf1),
    .opa_read(opa_r1), .opb_read(opb_r1),
    .ext_size_read(ext_r1),
    .load_valid(lv1), .issue_valid(iv1),
    .grant_tag(tag1), .block_last(bl1),
    .zero_size(zs1), .busy(busy1)
  );

  mul_flux_scheduler #(.FLUX(2)) u2 (
    .clk(clk), .rst(rst),
    .opa_empty(opa_e2), .opb_empty(opb_e2),
    .ext_size_empty(ext_e2), .ext_size_head(head2),
    .prod_full(pf2),
    .opa_read(opa_r2), .opb_read(opb_r2),
    .ext_size_read(ext_r2),
    .load_valid(lv2), .issue_valid(iv2),
    .grant_tag(tag2), .block_last(bl2),
    .zero_size(zs2), .busy(busy2)
  );

  mul_flux_scheduler #(.FLUX(3)) u3 (
    .clk(clk), .rst(rst),
    .opa_empty(opa_e3), .opb_empty(opb_e3),
    .ext_size_empty(ext_e3), .ext_size_head(head3),
    .prod_full(pf3),
    .opa_read(opa_r3), .opb_read(opb_r3),
    .ext_size_read(ext_r3),
    .load_valid(lv3), .issue_valid(iv3),
    .grant_tag(tag3), .block_last(bl3),
    .zero_size(zs3), .busy(busy3)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] ob, input logic lv,
                              input logic iv, input int tag,
                              input logic bl, input logic [1:0] bz);
    vec_t v;
    v.ob  = ob;
    v.lv  = lv;
    v.iv  = iv;
    v.tag = tag;
    v.bl  = bl;
    v.bz  = bz;
    return v;
  endfunction

  function automatic exp_t mke(input logic ld, input int tag,
                               input logic last);
    exp_t x;
    x.ld   = ld;
    x.tag  = 2'(tag);
    x.last = last;
    return x;
  endfunction

  initial begin
    // two loads then 18 alternating issues of two size-3 blocks
    vt[0] = mk(2'b00, 1'b1, 1'b0, 0, 1'b0, 2'b00);
    vt[1] = mk(2'b00, 1'b1, 1'b0, 1, 1'b0, 2'b01);
    for (int k = 0; k < 18; k++) begin
      vt[2+k] = mk(2'b11, 1'b0, 1'b1, k % 2, k >= 16,
                   (k == 17) ? 2'b10 : 2'b11);
    end
    vt[20] = mk(2'b11, 1'b0, 1'b0, 0, 1'b0, 2'b00);

    opa_e1 = 1'b1; opb_e1 = 1'b1; ext_e1 = 1'b1; pf1 = 1'b0;
    head1  = 7'd2;
    opa_e2 = 2'b00; opb_e2 = 2'b00; ext_e2 = 2'b00; pf2 = 2'b00;
    head2  = {7'd3, 7'd3};
    opa_e3 = 3'b111; opb_e3 = 3'b111; ext_e3 = 3'b111;
    pf3    = 3'b000;
    head3  = {7'd2, 7'd2, 7'd2};

    // reset with everything available: nothing may move
    repeat (2) @(negedge clk);
    chk("rst_load", lv2, 0);
    chk("rst_issue", iv2, 0);
    chk("rst_opb", opb_r2, 0);
    chk("rst_ext", ext_r2, 0);
    chk("rst_opa", opa_r2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_tag", tag2, 0);
    tick();
    rst = 1'b1;

    // table-driven: FLUX=2 fair rotation
    for (int i = 0; i < 21; i++) begin
      opb_e2 = vt[i].ob;
      ext_e2 = vt[i].ob;
      @(negedge clk);
      chk($sformatf("v%0d_load", i), lv2, vt[i].lv);
      chk($sformatf("v%0d_issue", i), iv2, vt[i].iv);
      if (vt[i].lv || vt[i].iv) begin
        chk($sformatf("v%0d_tag", i), tag2, vt[i].tag);
      end
      chk($sformatf("v%0d_last", i), bl2, vt[i].bl);
      chk($sformatf("v%0d_zero", i), zs2, 0);
      chk($sformatf("v%0d_busy", i), busy2, vt[i].bz);
      chk($sformatf("v%0d_opa", i), opa_r2,
          vt[i].iv ? (1 << vt[i].tag) : 0);
      chk($sformatf("v%0d_opb", i), opb_r2,
          vt[i].lv ? (1 << vt[i].tag) : 0);
      tick();
    end

    // scoreboard: flux 1 stalled by prod_full for 5 cycles
    ni[0] = 0;
    ni[1] = 0;
    sb.push_back(mke(1'b1, 0, 1'b0));
    sb.push_back(mke(1'b1, 1, 1'b0));
    begin
      int seq [18];
      int cnt [2];
      seq = '{0,1,0,1, 0,0,0,0,0, 1,0,1,0, 1,1,1,1,1};
      cnt[0] = 0;
      cnt[1] = 0;
      for (int k = 0; k < 18; k++) begin
        cnt[seq[k]]++;
        sb.push_back(mke(1'b0, seq[k], cnt[seq[k]] == 9));
      end
    end
    for (int c = 0; c < 60 && sb.size() > 0; c++) begin
      opb_e2 = (c < 2) ? 2'b00 : 2'b11;
      ext_e2 = (c < 2) ? 2'b00 : 2'b11;
      pf2    = (c >= 6 && c < 11) ? 2'b10 : 2'b00;
      @(negedge clk);
      if (lv2 || iv2) begin
        e = sb.pop_front();
        chk($sformatf("sb2_c%0d_load", c), lv2, e.ld);
        chk($sformatf("sb2_c%0d_tag", c), tag2, e.tag);
        chk($sformatf("sb2_c%0d_last", c), bl2, e.last);
        if (iv2) ni[tag2]++;
      end
      tick();
    end
    pf2 = 2'b00;
    chk("sb2_drain", sb.size(), 0);
    chk("sb2_n0", ni[0], 9);
    chk("sb2_n1", ni[1], 9);
    @(negedge clk);
    chk("sb2_idle_grant", lv2 | iv2, 0);
    chk("sb2_idle_busy", busy2, 0);
    tick();

    // zero-size block, then a size-1 block
    head2  = {7'd3, 7'd0};
    opb_e2 = 2'b10;
    ext_e2 = 2'b10;
    @(negedge clk);
    chk("z_load", lv2, 1);
    chk("z_zero", zs2, 1);
    chk("z_issue", iv2, 0);
    chk("z_tag", tag2, 0);
    chk("z_opb", opb_r2, 1);
    chk("z_ext", ext_r2, 1);
    tick();
    head2 = {7'd3, 7'd1};
    @(negedge clk);
    chk("z_busy_after", busy2, 0);
    chk("s1_load", lv2, 1);
    chk("s1_zero", zs2, 0);
    tick();
    opb_e2 = 2'b11;
    ext_e2 = 2'b11;
    @(negedge clk);
    chk("s1_issue", iv2, 1);
    chk("s1_last", bl2, 1);
    chk("s1_busy", busy2, 1);
    chk("s1_opa", opa_r2, 1);
    tick();
    @(negedge clk);
    chk("s1_done_issue", iv2, 0);
    chk("s1_done_busy", busy2, 0);
    tick();

    // FLUX=1: size 2 gives 4 issues, last on the 4th
    opa_e1 = 1'b0;
    opb_e1 = 1'b0;
    ext_e1 = 1'b0;
    @(negedge clk);
    chk("f1_load", lv1, 1);
    chk("f1_tag", tag1, 0);
    chk("f1_opb", opb_r1, 1);
    tick();
    opb_e1 = 1'b1;
    ext_e1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("f1_i%0d_issue", k), iv1, 1);
      chk($sformatf("f1_i%0d_last", k), bl1, k == 3);
      chk($sformatf("f1_i%0d_busy", k), busy1, 1);
      tick();
    end
    @(negedge clk);
    chk("f1_end_issue", iv1, 0);
    chk("f1_end_busy", busy1, 0);
    tick();

    // FLUX=3: wrap-around, then reset mid-block
    for (int c = 0; c < 5; c++) begin
      opa_e3 = 3'b000;
      opb_e3 = (c < 3) ? 3'b000 : 3'b111;
      ext_e3 = (c < 3) ? 3'b000 : 3'b111;
      @(negedge clk);
      chk($sformatf("f3a_c%0d_tag", c), tag3, c % 3);
      chk($sformatf("f3a_c%0d_load", c), lv3, c < 3);
      chk($sformatf("f3a_c%0d_issue", c), iv3, c >= 3);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("f3_rst_busy", busy3, 0);
    chk("f3_rst_grant", lv3 | iv3, 0);
    chk("f3_rst_opa", opa_r3, 0);
    #2;
    rst = 1'b1;
    tick();

    ni[0] = 0;
    ni[1] = 0;
    ni[2] = 0;
    for (int k = 0; k < 3; k++) sb.push_back(mke(1'b1, k, 1'b0));
    for (int k = 0; k < 12; k++) sb.push_back(mke(1'b0, k % 3, k >= 9));
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      opb_e3 = (c < 3) ? 3'b000 : 3'b111;
      ext_e3 = (c < 3) ? 3'b000 : 3'b111;
      @(negedge clk);
      if (lv3 || iv3) begin
        e = sb.pop_front();
        chk($sformatf("sb3_c%0d_load", c), lv3, e.ld);
        chk($sformatf("sb3_c%0d_tag", c), tag3, e.tag);
        chk($sformatf("sb3_c%0d_last", c), bl3, e.last);
        if (iv3) ni[tag3]++;
      end
      tick();
    end
    chk("sb3_drain", sb.size(), 0);
    chk("sb3_n0", ni[0], 4);
    chk("sb3_n2", ni[2], 4);
    @(negedge clk);
    chk("sb3_idle_busy", busy3, 0);
    chk("sb3_idle_grant", lv3 | iv3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
